// File: rtl/_alu_flags_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : _alu_flags_reg_pkg
//  Brief   : Shared types for the ALU status-flag stage: skid-buffer state
//            encoding and the {zr,ng} flag bundle used by the jump logic.
//  Revision: 1.0 - initial release
// ============================================================================
package _alu_flags_reg_pkg;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    // Flag bundle ordering {zr, ng}; the CPU jump logic indexes it the same way
    localparam int FLAG_W  = 2;
    localparam int FLAG_ZR = 1;
    localparam int FLAG_NG = 0;

    typedef struct packed {
        logic zr;
        logic ng;
    } flags_t;

    // Assemble a flag bundle from its two components
    function automatic flags_t pack_flags(input logic zr, input logic ng);
        flags_t f;
        f.zr = zr;
        f.ng = ng;
        return f;
    endfunction

endpackage : _alu_flags_reg_pkg
`default_nettype wire

// File: rtl/_alu_flags_reg_if.sv
`default_nettype none
// ============================================================================
//  Module  : _alu_flags_reg_if
//  Brief   : Upstream result handshake and downstream result/flag handshake
//            of the ALU status-flag stage.
//  Revision: 1.0 - initial release
// ============================================================================
interface _alu_flags_reg_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zr;
    logic             out_ng;
    logic             out_valid;
    logic             out_ready;

    // Producer of ALU results and consumer of flagged results
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_zr, out_ng, out_valid
    );

    // The flag stage itself
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_zr, out_ng, out_valid
    );
endinterface : _alu_flags_reg_if
`default_nettype wire

// File: rtl/_alu_flags_reg_zr_detect.sv
`default_nettype none
// ============================================================================
//  Module  : _zr_detect
//  Brief   : Combinational zero/negative detect. One _or8way per byte slice,
//            then a final OR across the slice results.
//  Revision: 1.0 - initial release
// ============================================================================
module _zr_detect #(
    parameter int WIDTH = 16
) (
    input  wire logic [WIDTH-1:0] data,
    output logic                  zr,
    output logic                  ng
);
    localparam int c_slices = WIDTH / 8;

    logic [c_slices-1:0] w_slice_or;

    generate
        for (genvar gi = 0; gi < c_slices; gi++) begin : g_slice
            _or8way u_or8way (
                .a (data[8*gi +: 8]),
                .y (w_slice_or[gi])
            );
        end
    endgenerate

    // Word is zero only when no slice has a set bit; sign is simply the MSB
    assign zr = ~(|w_slice_or);
    assign ng = data[WIDTH-1];

endmodule : _zr_detect
`default_nettype wire

// File: rtl/_or8way.sv
`default_nettype none
// ============================================================================
//  Module  : _or8way
//  Brief   : 8-input OR gate, one per 8-bit slice of the result word.
//  Revision: 1.0 - initial release
// ============================================================================
module _or8way (
    input  wire logic [7:0] a,
    output logic            y
);
    assign y = |a;
endmodule : _or8way
`default_nettype wire

// File: rtl/_alu_flags_reg.sv
`default_nettype none
// ============================================================================
//  Module  : _alu_flags_reg
//  Brief   : Registered status-flag stage. Computes zr/ng on incoming ALU
//            results, carries word+flags through a two-entry skid buffer,
//            and keeps a saturating count of zero results.
//  Revision: 1.0 - initial release
// ============================================================================
module _alu_flags_reg
    import _alu_flags_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    _alu_flags_reg_if.slave       bus,
    input  wire logic             clr_cnt,
    output logic [CNT_W-1:0]      zero_cnt
);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    skid_state_t      r_state;
    skid_state_t      w_state_nxt;

    logic [WIDTH-1:0] r_main_data;
    flags_t           r_main_flags;
    logic [WIDTH-1:0] r_skid_data;
    flags_t           r_skid_flags;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_zero_cnt;

    logic             w_zr;
    logic             w_ng;
    flags_t           w_in_flags;
    logic             w_accept;
    logic             w_pop;
    logic             w_ld_main_in;
    logic             w_ld_main_skid;
    logic             w_ld_skid;

    _zr_detect #(
        .WIDTH (WIDTH)
    ) u_zr_detect (
        .data (bus.in_data),
        .zr   (w_zr),
        .ng   (w_ng)
    );

    assign w_in_flags = pack_flags(w_zr, w_ng);
    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_pop      = r_out_valid & bus.out_ready;

    // State register plus registered handshake outputs derived from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Next-state and load selects for the main and skid entries
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_ld_main_in = 1'b1;
                    w_state_nxt  = ST_ONE;
                end
            end
            ST_ONE: begin
                case ({w_accept, w_pop})
                    2'b11: w_ld_main_in = 1'b1;
                    2'b10: begin
                        w_ld_skid   = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                    2'b01: w_state_nxt = ST_EMPTY;
                    default: ;
                endcase
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_ld_main_skid = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Data/flag storage; flags travel with their word so they never disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data  <= '0;
            r_main_flags <= '0;
            r_skid_data  <= '0;
            r_skid_flags <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main_data  <= bus.in_data;
                r_main_flags <= w_in_flags;
            end else if (w_ld_main_skid) begin
                r_main_data  <= r_skid_data;
                r_main_flags <= r_skid_flags;
            end
            if (w_ld_skid) begin
                r_skid_data  <= bus.in_data;
                r_skid_flags <= w_in_flags;
            end
        end
    end

    // Saturating zero-result counter; clear takes priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_cnt <= '0;
        end else if (clr_cnt) begin
            r_zero_cnt <= '0;
        end else if (w_accept && w_zr && (r_zero_cnt != c_cnt_max)) begin
            r_zero_cnt <= r_zero_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main_data;
    assign bus.out_zr    = r_main_flags.zr;
    assign bus.out_ng    = r_main_flags.ng;
    assign zero_cnt      = r_zero_cnt;

endmodule : _alu_flags_reg
`default_nettype wire

// File: doc/_alu_flags_reg.md
Name: _alu_flags_reg

Overview:
- Registered status-flag stage directly downstream of the 8-way OR reduction, in the ALU/CPU datapath.
- Accepts ALU result words over a valid/ready handshake and splits each word into 8-bit slices.
- Derives zr (all bits zero) and ng (MSB set) using one _or8way instance per slice.
- Presents result plus flags to the CPU control logic through a 2-entry skid buffer, and keeps a saturating count of zero results for debug.

Parameters:
- WIDTH, 16, result word width; must be a multiple of 8, legal range 8..64; one _or8way per 8-bit slice.
- CNT_W, 8, width of the zero-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  ALU result word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  stage can accept a word this cycle.
- out_data  output  WIDTH  registered result word.
- out_zr  output  1  1 when out_data == 0.
- out_ng  output  1  1 when out_data[WIDTH-1] == 1.
- out_valid  output  1  out_data, out_zr and out_ng are valid.
- out_ready  input  1  consumer accepts this cycle.
- clr_cnt  input  1  synchronous clear of zero_cnt.
- zero_cnt  output  CNT_W  saturating count of zero results accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_data=0, out_zr=0, out_ng=0, out_valid=0, zero_cnt=0. in_ready=1 (buffer empty).
- Flag compute:
  - Combinational on in_data, using WIDTH/8 _or8way instances plus an OR tree: zr = ~(OR of all slices); ng = in_data[WIDTH-1].
  - Flags are captured together with the data word, so they are always consistent with out_data.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Latency: 1 cycle. A word accepted at edge N is visible on out_* after edge N.
- Skid buffer: two entries, main (drives out_*) and skid. States:
  - EMPTY: out_valid=0, in_ready=1. On accept: load main -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept & pop: load main with new word, stay ONE.
    - Accept & no pop: load skid -> FULL.
    - Pop & no accept -> EMPTY.
    - Neither: hold.
  - FULL: out_valid=1, in_ready=0. On pop: main <= skid -> ONE. Otherwise hold.
- Throughput: with out_ready held 1, one word per cycle, no bubbles.
- in_ready is registered, taken from the state only, with no combinational path from out_ready.
- While out_valid=1 and out_ready=0, out_data, out_zr and out_ng hold stable.
- Words are never dropped or duplicated, and ordering is FIFO.
- in_valid while in_ready=0 is ignored; upstream must hold the word.
- zero_cnt:
  - Increments by 1 on each input transfer whose zr=1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - clr_cnt wins over a simultaneous increment, giving 0.
- Async reset asserted mid-operation: all state returns to the reset values immediately. Buffered words are discarded.

Decomposition:
- Shared package/header: state encoding (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2) and a flag-bundle constant for {zr,ng} ordering, reused by the CPU jump logic.
- One sub-module is natural: _zr_detect. It is a generate loop of _or8way instances plus a final _or reduction, outputs zr/ng, and is combinational.
- The skid buffer FSM and counter live in _alu_flags_reg.

Test Plan:
- Reset: assert rst_n=0 mid-stream with FULL state -> out_valid=0, in_ready=1, zero_cnt=0 immediately, without waiting for a clock.
- Flags (WIDTH=16, out_ready=1): push 16'h0000, 16'h8000, 16'h0100, 16'hFFFF -> (zr,ng) = (1,0), (0,1), (0,0), (0,1), each one cycle after acceptance.
- Backpressure: out_ready=0, push 16'h0001 then 16'h0002 -> in_ready=0 after the 2nd. A 3rd word 16'h0003 is held off. Release out_ready -> outputs 0001, 0002, 0003 in order, none lost.
- Streaming: out_ready=1, push 10 back-to-back words -> 10 consecutive out_valid cycles, in_ready stays 1.
- Counter: CNT_W=2, push five 16'h0000 words -> zero_cnt 1,2,3,3,3. Assert clr_cnt together with a zero push -> zero_cnt=0.
- Parameter: WIDTH=8, push 8'h00 and 8'h80 -> zr=1, then ng=1, zr=0.
